// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared constants and types for the ENC frame receive path.
//               The key must match the encryption key used by the ALU ENC
//               opcode on the transmit side.
// Contents    : ENC_KEY, ENC_SYNC, ENC_MAX_LEN, dec_state_e, sat_inc8()
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    // Default XOR key shared with the ALU ENC opcode.
    localparam logic [7:0] ENC_KEY     = 8'hAB;
    // Decrypted frame-start marker.
    localparam logic [7:0] ENC_SYNC    = 8'h5A;
    // Largest legal payload length in bytes.
    localparam int         ENC_MAX_LEN = 15;

    // Frame parser states.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } dec_state_e;

    // Increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word fall-through FIFO. The head entry is
//               presented on data_o whenever the FIFO is not empty; when it
//               empties, data_o keeps showing the last entry that left.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push_i, data_i  - write strobe and data (ignored when full)
//               pop_i           - remove head entry (ignored when empty)
//               full_o, empty_o - occupancy flags
//               data_o          - head entry / last popped entry
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of 2, at least 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // index bits are equal; pointers simply wrap.
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] last_q;

    logic w_do_push;
    logic w_do_pop;
    logic w_full;
    logic w_empty;

    assign w_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_empty   = (wr_q == rd_q);
    assign w_do_push = push_i & ~w_full;
    assign w_do_pop  = pop_i & ~w_empty;

    assign full_o  = w_full;
    assign empty_o = w_empty;
    // When empty the slot under rd_q is stale (or the next write target),
    // so the last value that left the FIFO is shown instead.
    assign data_o  = w_empty ? last_q : mem_q[rd_q[AW-1:0]];

    // Storage needs no reset: it is only ever read when occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            if (w_do_push) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (w_do_pop) begin
                rd_q   <= rd_q + PTR_ONE;
                last_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enc_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : enc_frame_decoder
// Description : Receive side of the ALU ENC operation. Decrypts an XOR-keyed
//               byte stream, parses SYNC / LEN / payload / checksum frames,
//               and streams payload bytes out as a/b operand nibbles through
//               a small FIFO. Payload is released before the checksum is
//               known; frame_err tells the consumer to discard it.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               in_data/in_valid/in_ready    - encrypted input stream
//               out_a/out_b/out_valid/out_ready - decrypted payload stream
//               key_we, key_in        - key load (honoured in HUNT only)
//               frame_ok, frame_err   - one-cycle frame result pulses
//               ok_cnt, err_cnt       - saturating frame counters
// Revision    : 1.0 - initial release
// ============================================================================
module enc_frame_decoder
    import enc_pkg::*;
#(
    parameter logic [7:0] KEY     = ENC_KEY,
    parameter logic [7:0] SYNC    = ENC_SYNC,
    parameter int         MAX_LEN = ENC_MAX_LEN,
    parameter int         DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    input  logic       key_we,
    input  logic [7:0] key_in,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    dec_state_e state_q, state_d;
    logic [7:0] key_q,   key_d;
    logic [7:0] chk_q,   chk_d;
    logic [7:0] rem_q,   rem_d;
    logic       ok_q,    ok_d;
    logic       err_q,   err_d;
    logic [7:0] okc_q,   okc_d;
    logic [7:0] errc_q,  errc_d;

    logic       w_accept;
    logic [7:0] w_dec;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    // Only the payload state writes the FIFO, so only it can stall input.
    assign in_ready = !((state_q == ST_PAYLOAD) && w_full);
    assign w_accept = in_valid & in_ready;
    assign w_dec    = in_data ^ key_q;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign out_a     = w_head[7:4];
    assign out_b     = w_head[3:0];

    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign ok_cnt    = okc_q;
    assign err_cnt   = errc_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_dec),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_o  (w_head)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        chk_d   = chk_q;
        rem_d   = rem_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        okc_d   = okc_q;
        errc_d  = errc_q;
        w_push  = 1'b0;

        // A byte accepted together with key_we still uses the old key,
        // because w_dec is built from key_q.
        if ((state_q == ST_HUNT) && key_we) begin
            key_d = key_in;
        end

        if (w_accept) begin
            case (state_q)
                ST_HUNT: begin
                    if (w_dec == SYNC) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_dec > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        errc_d  = sat_inc8(errc_q);
                        state_d = ST_HUNT;
                    end else if (w_dec == 8'd0) begin
                        chk_d   = 8'd0;
                        state_d = ST_CHECK;
                    end else begin
                        rem_d   = w_dec;
                        chk_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_push = 1'b1;
                    chk_d  = chk_q ^ w_dec;
                    if (rem_q == 8'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_dec == chk_q) begin
                        ok_d  = 1'b1;
                        okc_d = sat_inc8(okc_q);
                    end else begin
                        err_d  = 1'b1;
                        errc_d = sat_inc8(errc_q);
                    end
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            key_q   <= KEY;
            chk_q   <= 8'd0;
            rem_q   <= 8'd0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            okc_q   <= 8'd0;
            errc_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            chk_q   <= chk_d;
            rem_q   <= rem_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            okc_q   <= okc_d;
            errc_q  <= errc_d;
        end
    end

endmodule
`default_nettype wire
